alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Registered decode stage that turns a fetched RV32I instruction into the operand and control bundle consumed by the main ALU: A, B, CTRL[3:0], BRANCHCONDITION[2:0].
- Sits between instruction fetch / register-file read and the ALU.
- Holds one decoded entry behind a valid/ready handshake, with stall and flush support.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediates.
- NOBRANCH, 3'b011, BRANCHCONDITION value meaning "no branch". The ALU drives its flag to 0 for this code.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- IN_VALID  input  1  INSTR/PC/RS1_DATA/RS2_DATA are valid.
- IN_READY  output  1  stage can accept an instruction this cycle.
- INSTR  input  32  RV32I instruction word.
- PC  input  XLEN  address of INSTR.
- RS1_DATA  input  XLEN  register-file read of INSTR[19:15].
- RS2_DATA  input  XLEN  register-file read of INSTR[24:20].
- FLUSH  input  1  discard the held entry (branch taken / redirect).
- OUT_VALID  output  1  decoded entry is valid.
- OUT_READY  input  1  ALU stage consumes the entry this cycle.
- A  output  XLEN  ALU operand A.
- B  output  XLEN  ALU operand B.
- CTRL  output  4  ALU operation code.
- BRANCHCONDITION  output  3  ALU branch-condition code.
- IMM  output  XLEN  decoded immediate (branch/jump offset, store offset).
- RS2_OUT  output  XLEN  RS2_DATA passed through for stores.
- RD  output  5  destination register.
- REG_WRITE  output  1  write-back enable. Forced to 0 when RD==0.
- MEM_READ  output  1  load instruction.
- MEM_WRITE  output  1  store instruction.
- ILLEGAL  output  1  entry is an undecodable opcode or funct.

Behaviour:
- ALU CTRL encoding: ADD=0000, SUB=0001, SLL=0010, SRL=0011, SRA=0100, AND=0101, OR=0110, XOR=0111, SLT=1000, SLTU=1001.
- BRANCHCONDITION encoding: BEQ=000, BNE=001, JMP=010, BLT=100, BGE=101, BLTU=110, BGEU=111, NOBRANCH=011.
- Decode is combinational from INSTR.
- All outputs except IN_READY are registered. Latency is 1 cycle from accepted input to OUT_VALID.
- Handshake:
  - IN_READY = ~OUT_VALID | OUT_READY (combinational).
  - Capture when IN_VALID & IN_READY.
  - OUT_VALID is set on capture; it clears when OUT_READY & ~capture.
  - While OUT_VALID & ~OUT_READY, all outputs hold stable.
- FLUSH priority:
  - FLUSH overrides capture: next-cycle OUT_VALID=0 and no new entry is loaded, even if IN_VALID.
  - FLUSH while OUT_VALID=0 has no effect.
- Operand and control mapping by opcode (INSTR[6:0]):
  - R-type 0110011: A=RS1, B=RS2. CTRL from funct3 and funct7[5]: 000/0 ADD, 000/1 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0 SRL, 101/1 SRA, 110 OR, 111 AND. REG_WRITE=1.
  - I-ALU 0010011: A=RS1, B=sign-extended imm[11:0]. Same CTRL map, except SUB does not exist. Shifts use B={27'b0,INSTR[24:20]}. SRAI is selected by INSTR[30]. Slli/srli/srai with INSTR[31:25] other than 0000000/0100000 is ILLEGAL.
  - LOAD 0000011: A=RS1, B=I-imm, CTRL=ADD, MEM_READ=1, REG_WRITE=1.
  - STORE 0100011: A=RS1, B=S-imm, CTRL=ADD, MEM_WRITE=1, RS2_OUT=RS2.
  - BRANCH 1100011: A=RS1, B=RS2, IMM=B-imm.
    - beq/bne: CTRL=SUB, BRANCHCONDITION=000/001.
    - blt/bge: CTRL=SLT, BRANCHCONDITION=100/101.
    - bltu/bgeu: CTRL=SLTU, BRANCHCONDITION=110/111.
    - funct3 010/011 is ILLEGAL.
  - JAL 1101111: A=PC, B=4, CTRL=ADD, BRANCHCONDITION=JMP, IMM=J-imm, REG_WRITE=1.
  - JALR 1100111: A=PC, B=4, CTRL=ADD, BRANCHCONDITION=JMP, IMM=I-imm, REG_WRITE=1.
  - LUI 0110111: A=0, B={INSTR[31:12],12'b0}, CTRL=ADD, REG_WRITE=1.
  - AUIPC 0010111: A=PC, B=U-imm, CTRL=ADD, REG_WRITE=1.
  - Anything else: ILLEGAL=1, CTRL=ADD, A=B=0, REG_WRITE=MEM_READ=MEM_WRITE=0, BRANCHCONDITION=NOBRANCH.
- Non-branch, non-jump entries always carry BRANCHCONDITION=NOBRANCH.
- Immediates are sign-extended to XLEN from INSTR[31]. B-imm and J-imm have bit 0 = 0.
- Reset (asynchronous, any cycle including mid-stall):
  - OUT_VALID=0.
  - A=B=IMM=RS2_OUT=0, RD=0, CTRL=0000.
  - BRANCHCONDITION=NOBRANCH.
  - REG_WRITE=MEM_READ=MEM_WRITE=ILLEGAL=0.
  - IN_READY=1 immediately after RST deasserts.

Test Plan:
- add x3,x1,x2 (0x002081B3), RS1=5, RS2=7, OUT_READY=1 -> next cycle OUT_VALID=1, A=5, B=7, CTRL=0000, RD=3, REG_WRITE=1, BRANCHCONDITION=011.
- srai x5,x6,4 (0x40435293), RS1=0x80000000 -> CTRL=0100, B=4, REG_WRITE=1. Then addi x0,x0,-1 (0xFFF00013) -> B=0xFFFFFFFF, REG_WRITE=0.
- bltu x1,x2,-8 (0xFE20ECE3) -> CTRL=1001, BRANCHCONDITION=110, IMM=0xFFFFFFF8, REG_WRITE=0. jal x1,16 (0x010000EF) at PC=0x100 -> A=0x100, B=4, BRANCHCONDITION=010, IMM=16.
- Stall: OUT_READY=0 for 3 cycles with IN_VALID=1 -> IN_READY=0 and outputs frozen. On OUT_READY=1 the next instruction loads the following cycle; no instruction is lost or duplicated.
- FLUSH and IN_VALID in the same cycle with OUT_VALID=1 -> next cycle OUT_VALID=0. Assert RST mid-stall -> all outputs reach reset values without a clock edge.
- Opcode 0x0000007F or branch funct3=010 -> ILLEGAL=1, REG_WRITE=0, MEM_WRITE=0, BRANCHCONDITION=011.

Source files
------------

// File: rtl/alu_decode_stage_if.sv
// Upstream (fetch/register read) and downstream (ALU) signals of the RV32I decode stage.
// The stage itself uses the slave modport; whoever feeds and drains it uses master.
interface alu_decode_stage_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [2:0]      branchcondition;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs2_out;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, a, b, ctrl, branchcondition, imm, rs2_out, rd,
        input  reg_write, mem_read, mem_write, illegal
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, a, b, ctrl, branchcondition, imm, rs2_out, rd,
        output reg_write, mem_read, mem_write, illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage: turns an instruction plus register reads into the ALU
// operand/control bundle, held in a single-entry valid/ready buffer with flush.
module alu_decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [2:0]  NOBRANCH = 3'b011
) (
    input logic          clk,
    input logic          rst,
    alu_decode_stage_if.slave bus
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [3:0] CtrlAdd  = 4'b0000;
    localparam logic [3:0] CtrlSub  = 4'b0001;
    localparam logic [3:0] CtrlSll  = 4'b0010;
    localparam logic [3:0] CtrlSrl  = 4'b0011;
    localparam logic [3:0] CtrlSra  = 4'b0100;
    localparam logic [3:0] CtrlAnd  = 4'b0101;
    localparam logic [3:0] CtrlOr   = 4'b0110;
    localparam logic [3:0] CtrlXor  = 4'b0111;
    localparam logic [3:0] CtrlSlt  = 4'b1000;
    localparam logic [3:0] CtrlSltu = 4'b1001;

    localparam logic [2:0]      BcJmp      = 3'b010;
    localparam logic [XLEN-1:0] LinkOffset = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs2;
        logic [3:0]      ctrl;
        logic [2:0]      bc;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } entry_t;

    localparam entry_t ResetEntry = '{
        a: '0, b: '0, imm: '0, rs2: '0, ctrl: CtrlAdd, bc: NOBRANCH, rd: '0,
        reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, illegal: 1'b0
    };

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e state_q, state_d;
    entry_t entry_q, dec;
    logic   load;
    logic   in_ready;
    logic   illegal;
    logic   reg_write;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm, shamt;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign rd     = bus.instr[11:7];

    assign i_imm = XLEN'($signed(bus.instr[31:20]));
    assign s_imm = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
    assign b_imm = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                  bus.instr[11:8], 1'b0}));
    assign j_imm = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                  bus.instr[30:21], 1'b0}));
    assign u_imm = XLEN'($signed({bus.instr[31:12], 12'b0}));
    assign shamt = XLEN'(bus.instr[24:20]);

    // alt selects SUB for funct3 000 and SRA for funct3 101.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? CtrlSub : CtrlAdd;
            3'b001:  op = CtrlSll;
            3'b010:  op = CtrlSlt;
            3'b011:  op = CtrlSltu;
            3'b100:  op = CtrlXor;
            3'b101:  op = alt ? CtrlSra : CtrlSrl;
            3'b110:  op = CtrlOr;
            default: op = CtrlAnd;
        endcase
        return op;
    endfunction

    always_comb begin
        dec       = ResetEntry;
        dec.rd    = rd;
        illegal   = 1'b0;
        reg_write = 1'b0;
        case (opcode)
            OpReg: begin
                dec.a     = bus.rs1_data;
                dec.b     = bus.rs2_data;
                dec.ctrl  = alu_op(funct3, bus.instr[30]);
                reg_write = 1'b1;
            end
            OpImm: begin
                dec.a     = bus.rs1_data;
                dec.b     = i_imm;
                dec.imm   = i_imm;
                dec.ctrl  = alu_op(funct3, (funct3 == 3'b101) && bus.instr[30]);
                reg_write = 1'b1;
                if (funct3 == 3'b001) begin
                    dec.b   = shamt;
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec.b   = shamt;
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OpLoad: begin
                dec.a        = bus.rs1_data;
                dec.b        = i_imm;
                dec.imm      = i_imm;
                dec.mem_read = 1'b1;
                reg_write    = 1'b1;
            end
            OpStore: begin
                dec.a         = bus.rs1_data;
                dec.b         = s_imm;
                dec.imm       = s_imm;
                dec.rs2       = bus.rs2_data;
                dec.mem_write = 1'b1;
            end
            OpBranch: begin
                dec.a   = bus.rs1_data;
                dec.b   = bus.rs2_data;
                dec.imm = b_imm;
                // Branch-condition codes coincide with the RV32I branch funct3 values.
                dec.bc  = funct3;
                case (funct3)
                    3'b000, 3'b001: dec.ctrl = CtrlSub;
                    3'b100, 3'b101: dec.ctrl = CtrlSlt;
                    3'b110, 3'b111: dec.ctrl = CtrlSltu;
                    default:        illegal  = 1'b1;
                endcase
            end
            OpJal, OpJalr: begin
                dec.a     = bus.pc;
                dec.b     = LinkOffset;
                dec.bc    = BcJmp;
                dec.imm   = (opcode == OpJal) ? j_imm : i_imm;
                reg_write = 1'b1;
            end
            OpLui: begin
                dec.b     = u_imm;
                dec.imm   = u_imm;
                reg_write = 1'b1;
            end
            OpAuipc: begin
                dec.a     = bus.pc;
                dec.b     = u_imm;
                dec.imm   = u_imm;
                reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            dec         = ResetEntry;
            dec.illegal = 1'b1;
        end else begin
            dec.reg_write = reg_write && (rd != 5'd0);
        end
    end

    // A flush only matters while an entry is held; an empty stage still accepts.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        in_ready = (state_q == StEmpty) || bus.out_ready;
        unique case (state_q)
            StEmpty: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (bus.flush) begin
                    state_d = StEmpty;
                end else if (bus.in_valid && bus.out_ready) begin
                    load = 1'b1;
                end else if (bus.out_ready) begin
                    state_d = StEmpty;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            entry_q <= ResetEntry;
        end else begin
            state_q <= state_d;
            if (load) begin
                entry_q <= dec;
            end
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = (state_q == StFull);
    assign bus.a               = entry_q.a;
    assign bus.b               = entry_q.b;
    assign bus.ctrl            = entry_q.ctrl;
    assign bus.branchcondition = entry_q.bc;
    assign bus.imm             = entry_q.imm;
    assign bus.rs2_out         = entry_q.rs2;
    assign bus.rd              = entry_q.rd;
    assign bus.reg_write       = entry_q.reg_write;
    assign bus.mem_read        = entry_q.mem_read;
    assign bus.mem_write       = entry_q.mem_write;
    assign bus.illegal         = entry_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed decode table, stall/flush/reset sequences,
// then a randomized handshake stream against a behavioural decode model.
module tb_alu_decode_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_decode_stage_if #(.XLEN(32)) bus ();

    alu_decode_stage #(.XLEN(32), .NOBRANCH(3'b011)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a, b, imm, rs2o;
        logic [3:0]  ctrl;
        logic [2:0]  bc;
        logic [4:0]  rd;
        logic        rw, mr, mw, ill;
        logic        rd_care, imm_care, rs2_care;
    } exp_t;

    typedef struct {
        logic [31:0] instr, pc, rs1, rs2;
        exp_t        e;
    } vec_t;

    localparam logic [3:0] F3_OP [8] = '{4'h0, 4'h2, 4'h8, 4'h9, 4'h7, 4'h3, 4'h6, 4'h5};

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];
    logic [6:0] ops [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_entry(input string tag, input exp_t e);
        chk({tag, ".a"}, bus.a, e.a);
        chk({tag, ".b"}, bus.b, e.b);
        chk({tag, ".ctrl"}, 32'(bus.ctrl), 32'(e.ctrl));
        chk({tag, ".bc"}, 32'(bus.branchcondition), 32'(e.bc));
        chk({tag, ".reg_write"}, 32'(bus.reg_write), 32'(e.rw));
        chk({tag, ".mem_read"}, 32'(bus.mem_read), 32'(e.mr));
        chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(e.mw));
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
        if (e.rd_care) chk({tag, ".rd"}, 32'(bus.rd), 32'(e.rd));
        if (e.imm_care) chk({tag, ".imm"}, bus.imm, e.imm);
        if (e.rs2_care) chk({tag, ".rs2_out"}, bus.rs2_out, e.rs2o);
    endtask

    function automatic vec_t mkv(input logic [31:0] instr, pc, rs1, rs2, a, b, ctrl, bc, rd,
                                 input logic [31:0] rw, mr, mw, ill, imm, rs2o);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.e.a = a; v.e.b = b; v.e.ctrl = ctrl[3:0]; v.e.bc = bc[2:0]; v.e.rd = rd[4:0];
        v.e.rw = rw[0]; v.e.mr = mr[0]; v.e.mw = mw[0]; v.e.ill = ill[0];
        v.e.imm = imm; v.e.rs2o = rs2o;
        v.e.rd_care  = rw[0];
        v.e.imm_care = (instr[6:0] inside {7'h63, 7'h6F, 7'h67, 7'h23}) && !ill[0];
        v.e.rs2_care = (instr[6:0] == 7'h23) && !ill[0];
        return v;
    endfunction

    // Behavioural decode from the instruction-set rules, immediates by arithmetic shifts.
    function automatic exp_t ref_decode(input logic [31:0] ins, pc, rs1, rs2);
        exp_t r;
        logic signed [31:0] sx;
        logic [31:0] iimm, simm, bimm, jimm, uimm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        sx   = $signed(ins);
        f3   = ins[14:12];
        f7   = ins[31:25];
        iimm = 32'(sx >>> 20);
        simm = (iimm & 32'hFFFF_FFE0) | {27'b0, ins[11:7]};
        bimm = (32'(sx >>> 19) & 32'hFFFF_F000) | {20'b0, ins[7], ins[30:25], ins[11:8], 1'b0};
        jimm = (32'(sx >>> 11) & 32'hFFF0_0000) | {12'b0, ins[19:12], ins[20], ins[30:21], 1'b0};
        uimm = ins & 32'hFFFF_F000;
        r = '{a: 0, b: 0, imm: 0, rs2o: 0, ctrl: 0, bc: 3'b011, rd: ins[11:7], rw: 0, mr: 0,
              mw: 0, ill: 0, rd_care: 0, imm_care: 0, rs2_care: 0};
        case (ins[6:0])
            7'h33: begin
                r.a = rs1; r.b = rs2; r.rw = 1; r.ctrl = F3_OP[f3];
                if (f3 == 0 && ins[30]) r.ctrl = 4'h1;
                if (f3 == 5 && ins[30]) r.ctrl = 4'h4;
            end
            7'h13: begin
                r.a = rs1; r.b = iimm; r.rw = 1; r.ctrl = F3_OP[f3];
                if (f3 == 1) begin r.b = {27'b0, ins[24:20]}; r.ill = (f7 != 0); end
                if (f3 == 5) begin
                    r.b = {27'b0, ins[24:20]};
                    r.ill = (f7 != 0) && (f7 != 7'h20);
                    if (ins[30]) r.ctrl = 4'h4;
                end
            end
            7'h03: begin r.a = rs1; r.b = iimm; r.mr = 1; r.rw = 1; end
            7'h23: begin
                r.a = rs1; r.b = simm; r.mw = 1; r.rs2o = rs2; r.rs2_care = 1;
                r.imm = simm; r.imm_care = 1;
            end
            7'h63: begin
                r.ill = (f3 == 2) || (f3 == 3);
                r.a = rs1; r.b = rs2; r.bc = f3; r.imm = bimm; r.imm_care = 1;
                r.ctrl = (f3 < 4) ? 4'h1 : (f3 < 6) ? 4'h8 : 4'h9;
            end
            7'h6F, 7'h67: begin
                r.a = pc; r.b = 4; r.bc = 3'b010; r.rw = 1; r.imm_care = 1;
                r.imm = (ins[6:0] == 7'h6F) ? jimm : iimm;
            end
            7'h37: begin r.b = uimm; r.rw = 1; end
            7'h17: begin r.a = pc; r.b = uimm; r.rw = 1; end
            default: r.ill = 1;
        endcase
        if (r.ill) begin
            r = '{a: 0, b: 0, imm: 0, rs2o: 0, ctrl: 0, bc: 3'b011, rd: 0, rw: 0, mr: 0,
                  mw: 0, ill: 1, rd_care: 0, imm_care: 0, rs2_care: 0};
        end
        r.rw      = r.rw && (r.rd != 0);
        r.rd_care = r.rw;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, pc, rs1, rs2,
                         input logic ordy, input logic fl);
        bus.in_valid = v; bus.instr = ins; bus.pc = pc;
        bus.rs1_data = rs1; bus.rs2_data = rs2;
        bus.out_ready = ordy; bus.flush = fl;
    endtask

    initial begin
        bit   mv;
        exp_t mexp;
        logic v, ordy, fl;
        logic [31:0] ins, pc, rs1, rs2;

        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};
        vecs.push_back(mkv(32'h002081B3, 0, 5, 7, 5, 7, 0, 3, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(32'h40435293, 0, 32'h8000_0000, 0, 32'h8000_0000, 4, 4, 3, 5,
                           1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(32'hFFF00013, 0, 32'h12, 0, 32'h12, 32'hFFFF_FFFF, 0, 3, 0,
                           0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(32'hFE20ECE3, 0, 1, 2, 1, 2, 9, 6, 0, 0, 0, 0, 0,
                           32'hFFFF_FFF8, 0));
        vecs.push_back(mkv(32'h010000EF, 32'h100, 0, 0, 32'h100, 4, 0, 2, 1, 1, 0, 0, 0, 16, 0));
        vecs.push_back(mkv(32'h0000007F, 0, 9, 9, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(32'h00002063, 0, 9, 9, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(32'h123452B7, 0, 9, 0, 0, 32'h1234_5000, 0, 3, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(32'h0020A423, 0, 32'h1000, 32'hCAFE, 32'h1000, 8, 0, 3, 0,
                           0, 0, 1, 0, 8, 32'hCAFE));
        vecs.push_back(mkv(32'hFFC1A203, 0, 32'h2000, 0, 32'h2000, 32'hFFFF_FFFC, 0, 3, 4,
                           1, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(32'h02009093, 0, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(32'h402081B3, 0, 10, 3, 10, 3, 1, 3, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(32'h00C100E7, 32'h200, 0, 0, 32'h200, 4, 0, 2, 1, 1, 0, 0, 0, 12, 0));
        vecs.push_back(mkv(32'h00001397, 32'h40, 0, 0, 32'h40, 32'h1000, 0, 3, 7,
                           1, 0, 0, 0, 0, 0));

        // Reset state, observed while reset is still held.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset.out_valid", 32'(bus.out_valid), 0);
        chk("reset.in_ready", 32'(bus.in_ready), 1);
        chk("reset.bc", 32'(bus.branchcondition), 3);
        chk("reset.a", bus.a, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_reset.in_ready", 32'(bus.in_ready), 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 1, 0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 1);
            check_entry($sformatf("vec%0d", i), vecs[i].e);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1 chk("drain.out_valid", 32'(bus.out_valid), 0);

        // Stall: held add must stay put while the jal waits.
        @(negedge clk);
        drive(1, 32'h002081B3, 0, 5, 7, 1, 0);
        @(negedge clk);
        drive(1, 32'h010000EF, 32'h100, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall.in_ready", 32'(bus.in_ready), 0);
            chk("stall.out_valid", 32'(bus.out_valid), 1);
            chk("stall.a", bus.a, 5);
            chk("stall.b", bus.b, 7);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 chk("unstall.in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        chk("unstall.a", bus.a, 32'h100);
        chk("unstall.bc", 32'(bus.branchcondition), 2);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1 chk("no_dup.out_valid", 32'(bus.out_valid), 0);

        // Flush beats a simultaneous capture; flush on an empty stage is ignored.
        @(negedge clk);
        drive(1, 32'h002081B3, 0, 5, 7, 1, 0);
        @(negedge clk);
        drive(1, 32'h010000EF, 32'h100, 0, 0, 0, 1);
        @(posedge clk);
        #1 chk("flush.out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        drive(1, 32'h123452B7, 0, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        chk("flush_empty.out_valid", 32'(bus.out_valid), 1);
        chk("flush_empty.b", bus.b, 32'h1234_5000);

        // Reset asserted mid-stall clears outputs with no clock edge.
        @(negedge clk);
        drive(1, 32'h002081B3, 0, 5, 7, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.out_valid", 32'(bus.out_valid), 0);
        chk("async_rst.in_ready", 32'(bus.in_ready), 1);
        chk("async_rst.a", bus.a, 0);
        chk("async_rst.b", bus.b, 0);
        chk("async_rst.imm", bus.imm, 0);
        chk("async_rst.rs2_out", bus.rs2_out, 0);
        chk("async_rst.rd", 32'(bus.rd), 0);
        chk("async_rst.bc", 32'(bus.branchcondition), 3);
        chk("async_rst.reg_write", 32'(bus.reg_write), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Randomized stream against the one-entry buffer model.
        mv = 1'b0;
        mexp = ref_decode(32'h0000007F, 0, 0, 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 9) == 0);
            ins  = $urandom;
            ins[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1) ins[31:25] = {1'b0, ins[30], 5'b0};
            pc  = $urandom & 32'hFFFF_FFFC;
            rs1 = $urandom;
            rs2 = $urandom;
            drive(v, ins, pc, rs1, rs2, ordy, fl);
            #1 chk("rand.in_ready", 32'(bus.in_ready), 32'(!mv || ordy));
            if (fl && mv) begin
                mv = 1'b0;
            end else if (v && (!mv || ordy)) begin
                mexp = ref_decode(ins, pc, rs1, rs2);
                mv   = 1'b1;
            end else if (ordy) begin
                mv = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rand.out_valid", 32'(bus.out_valid), 32'(mv));
            if (mv) check_entry($sformatf("rand%0d", cyc), mexp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
